// File: rtl/terrain_controller.sv
`default_nettype none
// ============================================================================
// Module : terrain_controller (with terrain_rom map store)
// Ground-map column lookup, terrain pixel colour, collision and scroll FSM.
// Rev    : 1.0
// ============================================================================

module terrain_rom (
    input  logic        clk_i,
    input  logic [7:0]  addr,
    output logic [17:0] data_o
);
    logic [17:0] data_d;
    logic [17:0] data_q;

    // {upper, lower}; odd segments beyond the start area have no platform
    always_comb begin
        data_d = 18'd0;
        case (addr)
            8'd0:    data_d = {9'd100, 9'd300};
            8'd1:    data_d = {9'h1FF, 9'd250};
            default: data_d = {(addr[0] ? 9'h1FF : 9'd120), 9'd240 + {4'd0, addr[4:0]}};
        endcase
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;
endmodule

module terrain_controller #(
    parameter int          H_TOTAL   = 1344,
    parameter int          SEG_SHIFT = 5,
    parameter int          MAP_SEGS  = 256,
    parameter int          SCROLL_DX = 2,
    parameter int          PLAT_T    = 8,
    parameter int          CHAR_MID  = 160,
    parameter logic [8:0]  NO_SURF   = 9'h1FF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        disp_active,
    input  logic        scrn_refresh,
    input  logic        fwd,
    input  logic        rvs,
    input  logic        char_body,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic [8:0]  ht_upper,
    output logic [8:0]  ht_lower,
    output logic        terrain_active,
    output logic [11:0] color_o,
    output logic [12:0] scroll_x,
    output logic        blocked
);
    localparam int AW = $clog2(MAP_SEGS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FWD   = 3'd1;
    localparam logic [2:0] S_RVS   = 3'd2;
    localparam logic [2:0] S_BLK_F = 3'd3;
    localparam logic [2:0] S_BLK_R = 3'd4;

    logic [10:0]   w_col;
    logic [12:0]   w_world;
    logic [AW-1:0] addr_d, addr_q;
    logic [1:0]    vld_d, vld_q;
    logic [17:0]   w_rom_data;
    logic [8:0]    ht_upper_d, ht_upper_q, ht_lower_d, ht_lower_q;
    logic          w_up_hit, w_low_hit, w_surface, w_hit, w_front;
    logic          hit_f_d, hit_f_q, hit_b_d, hit_b_q;
    logic [2:0]    state_d, state_q;
    logic [12:0]   scroll_d, scroll_q;
    logic          w_f_only, w_r_only;

    // Fetch three columns ahead so the registered heights line up with pix_x
    always_comb begin
        w_col   = (pix_x >= 11'(H_TOTAL - 3)) ? pix_x - 11'(H_TOTAL - 3) : pix_x + 11'd3;
        w_world = scroll_q + {2'b00, w_col};
        addr_d  = w_world[SEG_SHIFT +: AW];
        vld_d   = {vld_q[0], 1'b1};
        ht_upper_d = vld_q[1] ? w_rom_data[17:9] : NO_SURF;
        ht_lower_d = vld_q[1] ? w_rom_data[8:0]  : NO_SURF;
    end

    terrain_rom u_rom (
        .clk_i  (clk_i),
        .addr   (addr_q),
        .data_o (w_rom_data)
    );

    always_comb begin
        w_low_hit = (ht_lower_q != NO_SURF) && (pix_y >= {2'b00, ht_lower_q});
        w_up_hit  = (ht_upper_q != NO_SURF) && (pix_y >= {2'b00, ht_upper_q})
                    && (pix_y < {2'b00, ht_upper_q} + 11'(PLAT_T));
        w_surface = ((ht_upper_q != NO_SURF) && (pix_y == {2'b00, ht_upper_q}))
                    || ((ht_lower_q != NO_SURF) && (pix_y == {2'b00, ht_lower_q}));
        terrain_active = disp_active && (w_low_hit || w_up_hit);
        color_o = terrain_active ? (w_surface ? 12'hAAA : 12'h555) : 12'h000;
    end

    // A hit seen on the refresh cycle itself survives the clear for next frame
    always_comb begin
        w_hit   = char_body && terrain_active;
        w_front = (pix_x >= 11'(CHAR_MID));
        hit_f_d = (scrn_refresh ? 1'b0 : hit_f_q) | (w_hit & w_front);
        hit_b_d = (scrn_refresh ? 1'b0 : hit_b_q) | (w_hit & ~w_front);
    end

    always_comb begin
        state_d  = state_q;
        scroll_d = scroll_q;
        w_f_only = fwd & ~rvs;
        w_r_only = rvs & ~fwd;
        if (scrn_refresh) begin
            case (state_q)
                S_IDLE: begin
                    if (w_f_only) begin
                        state_d  = S_FWD;
                        scroll_d = scroll_q + 13'(SCROLL_DX);
                    end else if (w_r_only) begin
                        state_d  = S_RVS;
                        scroll_d = scroll_q - 13'(SCROLL_DX);
                    end
                end
                S_FWD: begin
                    if (w_r_only) begin
                        state_d  = S_RVS;
                        scroll_d = scroll_q - 13'(SCROLL_DX);
                    end else if (!w_f_only) begin
                        state_d  = S_IDLE;
                    end else if (hit_f_q) begin
                        state_d  = S_BLK_F;
                    end else begin
                        scroll_d = scroll_q + 13'(SCROLL_DX);
                    end
                end
                S_RVS: begin
                    if (w_f_only) begin
                        state_d  = S_FWD;
                        scroll_d = scroll_q + 13'(SCROLL_DX);
                    end else if (!w_r_only) begin
                        state_d  = S_IDLE;
                    end else if (hit_b_q) begin
                        state_d  = S_BLK_R;
                    end else begin
                        scroll_d = scroll_q - 13'(SCROLL_DX);
                    end
                end
                S_BLK_F: begin
                    if (w_r_only) begin
                        state_d  = S_RVS;
                        scroll_d = scroll_q - 13'(SCROLL_DX);
                    end else if (!fwd && !rvs) begin
                        state_d  = S_IDLE;
                    end
                end
                S_BLK_R: begin
                    if (w_f_only) begin
                        state_d  = S_FWD;
                        scroll_d = scroll_q + 13'(SCROLL_DX);
                    end else if (!fwd && !rvs) begin
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            vld_q      <= 2'b00;
            ht_upper_q <= NO_SURF;
            ht_lower_q <= NO_SURF;
            hit_f_q    <= 1'b0;
            hit_b_q    <= 1'b0;
            state_q    <= S_IDLE;
            scroll_q   <= 13'd0;
        end else begin
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            ht_upper_q <= ht_upper_d;
            ht_lower_q <= ht_lower_d;
            hit_f_q    <= hit_f_d;
            hit_b_q    <= hit_b_d;
            state_q    <= state_d;
            scroll_q   <= scroll_d;
        end
    end

    assign ht_upper = ht_upper_q;
    assign ht_lower = ht_lower_q;
    assign scroll_x = scroll_q;
    assign blocked  = (state_q == S_BLK_F) || (state_q == S_BLK_R);
endmodule

`default_nettype wire

// File: tb/tb_terrain_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_terrain_controller
// Directed self-checking bench for terrain_controller.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps

module tb_terrain_controller;
    localparam int H_TOTAL = 1344;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        disp_active = 1'b1;
    logic        scrn_refresh = 1'b0;
    logic        fwd = 1'b0;
    logic        rvs = 1'b0;
    logic        char_body = 1'b0;
    logic [10:0] pix_x = 11'd0;
    logic [10:0] pix_y = 11'd0;
    logic [8:0]  ht_upper, ht_lower;
    logic        terrain_active;
    logic [11:0] color_o;
    logic [12:0] scroll_x;
    logic        blocked;

    int n_checks = 0;
    int n_pass   = 0;

    terrain_controller dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .disp_active    (disp_active),
        .scrn_refresh   (scrn_refresh),
        .fwd            (fwd),
        .rvs            (rvs),
        .char_body      (char_body),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .ht_upper       (ht_upper),
        .ht_lower       (ht_lower),
        .terrain_active (terrain_active),
        .color_o        (color_o),
        .scroll_x       (scroll_x),
        .blocked        (blocked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        pix_x = (pix_x == 11'(H_TOTAL - 1)) ? 11'd0 : pix_x + 11'd1;
    endtask

    task automatic goto_x(input logic [10:0] x);
        for (int i = 0; i < 2 * H_TOTAL && pix_x != x; i++) tick();
        if (pix_x != x) begin
            n_checks++;
            $display("FAIL goto_x timeout: pix_x=%0d wanted %0d", pix_x, x);
        end
    endtask

    task automatic refresh();
        scrn_refresh = 1'b1;
        tick();
        scrn_refresh = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        fwd = 1'b0;
        rvs = 1'b0;
    endtask

    task automatic test_reset();
        pix_y = 11'd400;
        tick(); tick(); tick();
        n_checks++; if (scroll_x !== 13'd0) $display("FAIL rst_scroll: got %0d want 0", scroll_x); else n_pass++;
        n_checks++; if (ht_upper !== 9'h1FF) $display("FAIL rst_ht_upper: got %h want 1ff", ht_upper); else n_pass++;
        n_checks++; if (ht_lower !== 9'h1FF) $display("FAIL rst_ht_lower: got %h want 1ff", ht_lower); else n_pass++;
        n_checks++; if (blocked !== 1'b0) $display("FAIL rst_blocked: got %b want 0", blocked); else n_pass++;
        n_checks++; if (terrain_active !== 1'b0) $display("FAIL rst_active: got %b want 0", terrain_active); else n_pass++;
        n_checks++; if (color_o !== 12'h000) $display("FAIL rst_color: got %h want 000", color_o); else n_pass++;
        rst_i = 1'b0;
    endtask

    task automatic test_lookup();
        goto_x(11'd31);
        n_checks++; if (ht_upper !== 9'd100) $display("FAIL x31_upper: got %0d want 100", ht_upper); else n_pass++;
        n_checks++; if (ht_lower !== 9'd300) $display("FAIL x31_lower: got %0d want 300", ht_lower); else n_pass++;
        pix_y = 11'd300; #1;
        n_checks++; if (color_o !== 12'hAAA) $display("FAIL col_ground_surf: got %h want aaa", color_o); else n_pass++;
        pix_y = 11'd301; #1;
        n_checks++; if (color_o !== 12'h555) $display("FAIL col_ground_body: got %h want 555", color_o); else n_pass++;
        pix_y = 11'd100; #1;
        n_checks++; if (color_o !== 12'hAAA) $display("FAIL col_plat_surf: got %h want aaa", color_o); else n_pass++;
        pix_y = 11'd107; #1;
        n_checks++; if (terrain_active !== 1'b1) $display("FAIL plat_last_row: got %b want 1", terrain_active); else n_pass++;
        pix_y = 11'd108; #1;
        n_checks++; if (terrain_active !== 1'b0) $display("FAIL plat_below: got %b want 0", terrain_active); else n_pass++;
        pix_y = 11'd99; #1;
        n_checks++; if (color_o !== 12'h000) $display("FAIL sky_color: got %h want 000", color_o); else n_pass++;
        pix_y = 11'd350; disp_active = 1'b0; #1;
        n_checks++; if (terrain_active !== 1'b0) $display("FAIL blank_active: got %b want 0", terrain_active); else n_pass++;
        disp_active = 1'b1;
        tick();
        n_checks++; if (ht_upper !== 9'h1FF) $display("FAIL x32_upper: got %h want 1ff", ht_upper); else n_pass++;
        n_checks++; if (ht_lower !== 9'd250) $display("FAIL x32_lower: got %0d want 250", ht_lower); else n_pass++;
    endtask

    task automatic test_scroll();
        do_reset();
        fwd = 1'b1;
        for (int i = 0; i < 10; i++) refresh();
        n_checks++; if (scroll_x !== 13'd20) $display("FAIL fwd10_scroll: got %0d want 20", scroll_x); else n_pass++;
        do_reset();
        rvs = 1'b1;
        for (int i = 0; i < 11; i++) refresh();
        n_checks++; if (scroll_x !== 13'd8170) $display("FAIL rvs11_scroll: got %0d want 8170", scroll_x); else n_pass++;
        rvs = 1'b0;
    endtask

    task automatic test_line_wrap();
        do_reset();
        rvs = 1'b1;
        refresh();
        rvs = 1'b0;
        n_checks++; if (scroll_x !== 13'd8190) $display("FAIL wrap_scroll: got %0d want 8190", scroll_x); else n_pass++;
        tick(); tick(); tick();
        goto_x(11'd0);
        n_checks++; if (ht_lower !== 9'd271 || ht_upper !== 9'h1FF) $display("FAIL wrap_x0: got %0d/%0d want 511/271", ht_upper, ht_lower); else n_pass++;
        tick();
        n_checks++; if (ht_lower !== 9'd271 || ht_upper !== 9'h1FF) $display("FAIL wrap_x1: got %0d/%0d want 511/271", ht_upper, ht_lower); else n_pass++;
        tick();
        n_checks++; if (ht_lower !== 9'd300 || ht_upper !== 9'd100) $display("FAIL wrap_x2: got %0d/%0d want 100/300", ht_upper, ht_lower); else n_pass++;
        tick();
        n_checks++; if (ht_lower !== 9'd300 || ht_upper !== 9'd100) $display("FAIL wrap_x3: got %0d/%0d want 100/300", ht_upper, ht_lower); else n_pass++;
    endtask

    task automatic test_block();
        do_reset();
        fwd = 1'b1;
        refresh();
        goto_x(11'd200);
        pix_y = 11'd250;
        #1;
        n_checks++; if (terrain_active !== 1'b1) $display("FAIL blk_pixel_solid: got %b want 1", terrain_active); else n_pass++;
        char_body = 1'b1;
        tick();
        char_body = 1'b0;
        refresh();
        n_checks++; if (blocked !== 1'b1) $display("FAIL blk_set: got %b want 1", blocked); else n_pass++;
        n_checks++; if (scroll_x !== 13'd2) $display("FAIL blk_scroll: got %0d want 2", scroll_x); else n_pass++;
        refresh();
        n_checks++; if (blocked !== 1'b1 || scroll_x !== 13'd2) $display("FAIL blk_hold: got %b/%0d want 1/2", blocked, scroll_x); else n_pass++;
        fwd = 1'b0;
        rvs = 1'b1;
        refresh();
        n_checks++; if (blocked !== 1'b0) $display("FAIL blk_release: got %b want 0", blocked); else n_pass++;
        n_checks++; if (scroll_x !== 13'd0) $display("FAIL blk_rev_scroll: got %0d want 0", scroll_x); else n_pass++;
    endtask

    task automatic test_hit_on_refresh();
        goto_x(11'd100);
        pix_y = 11'd250;
        char_body = 1'b1;
        scrn_refresh = 1'b1;
        tick();
        char_body = 1'b0;
        scrn_refresh = 1'b0;
        n_checks++; if (blocked !== 1'b0 || scroll_x !== 13'd8190) $display("FAIL hit_same_cycle: got %b/%0d want 0/8190", blocked, scroll_x); else n_pass++;
        tick();
        refresh();
        n_checks++; if (blocked !== 1'b1 || scroll_x !== 13'd8190) $display("FAIL hit_next_frame: got %b/%0d want 1/8190", blocked, scroll_x); else n_pass++;
    endtask

    task automatic test_both();
        fwd = 1'b0;
        rvs = 1'b0;
        refresh();
        n_checks++; if (blocked !== 1'b0) $display("FAIL both_idle_exit: got %b want 0", blocked); else n_pass++;
        fwd = 1'b1;
        rvs = 1'b1;
        for (int i = 0; i < 5; i++) refresh();
        n_checks++; if (scroll_x !== 13'd8190 || blocked !== 1'b0) $display("FAIL both_hold: got %0d/%b want 8190/0", scroll_x, blocked); else n_pass++;
        rvs = 1'b0;
        refresh();
        n_checks++; if (scroll_x !== 13'd0) $display("FAIL both_then_fwd: got %0d want 0", scroll_x); else n_pass++;
        fwd = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        fwd = 1'b1;
        for (int i = 0; i < 20; i++) refresh();
        n_checks++; if (scroll_x !== 13'd40) $display("FAIL pre_rst_scroll: got %0d want 40", scroll_x); else n_pass++;
        goto_x(11'd500);
        rst_i = 1'b1;
        scrn_refresh = 1'b1;
        tick();
        scrn_refresh = 1'b0;
        fwd = 1'b0;
        n_checks++; if (scroll_x !== 13'd0) $display("FAIL mid_rst_scroll: got %0d want 0", scroll_x); else n_pass++;
        n_checks++; if (ht_upper !== 9'h1FF || ht_lower !== 9'h1FF) $display("FAIL mid_rst_ht: got %h/%h want 1ff/1ff", ht_upper, ht_lower); else n_pass++;
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        n_checks++; if (ht_lower !== 9'h1FF) $display("FAIL rel_2clk_lower: got %h want 1ff", ht_lower); else n_pass++;
        tick();
        n_checks++; if (ht_lower !== 9'd255 || ht_upper !== 9'h1FF) $display("FAIL rel_3clk_ht: got %0d/%0d want 511/255", ht_upper, ht_lower); else n_pass++;
        tick();
        n_checks++; if (ht_lower !== 9'd255 || ht_upper !== 9'h1FF) $display("FAIL rel_4clk_ht: got %0d/%0d want 511/255", ht_upper, ht_lower); else n_pass++;
        n_checks++; if (scroll_x !== 13'd0 || blocked !== 1'b0) $display("FAIL rel_state: got %0d/%b want 0/0", scroll_x, blocked); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_scroll();
        test_line_wrap();
        test_block();
        test_hit_on_refresh();
        test_both();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
